// File: rtl/mc_seq_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
package mc_seq_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam int unsigned TIMEOUT_DEF = 16;

endpackage

// File: rtl/mc_wdog.sv
// Memory-handshake wait counter: flags expiry on the TIMEOUT-th unacknowledged request cycle.
module mc_wdog
    import mc_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CNT_W = 8;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        cnt <= '0;
        else if (clear) cnt <= '0;
        else if (count) cnt <= cnt + 1'b1;
    end

    // count already excludes ack cycles, so a last-moment ack never expires
    assign expired = count && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the RV32I core (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional performance counters are built when MC_SEQ_PERF_EN is defined.
module mc_sequencer
    import mc_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic        is_R_i,
    input  logic        is_I_i,
    input  logic        is_S_i,
    input  logic        is_B_i,
    input  logic        is_J_i,
    input  logic        is_U_i,
    input  logic        is_load_i,
    input  logic        is_jalr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        br_taken_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        ir_en_o,
    output logic        mdr_en_o,
    output logic        pc_en_o,
    output logic        pc_sel_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        err_o,
    output logic [2:0]  state_o
`ifdef MC_SEQ_PERF_EN
    ,
    output logic [31:0] instret_o,
    output logic [31:0] stall_cnt_o
`endif
);

    state_t state, nxt;
    logic   req_pend;
    logic   err;
    logic   wd_clear, wd_count, wd_expired;
    logic   jump;

    // R/I/U only route to WB by default; no explicit decode needed
    logic unused_cls;
    assign unused_cls = ^{is_R_i, is_I_i, is_U_i};

    assign jump = is_J_i | is_jalr_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= FETCH;
            req_pend <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= nxt;
            req_pend <= imem_req_o && !imem_ack_i && !wd_expired;
            err      <= err | (nxt == TRAP);
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            FETCH:  if (imem_req_o && imem_ack_i) nxt = DECODE;
                    else if (wd_expired)          nxt = TRAP;
            DECODE: nxt = EXEC;
            EXEC:   if (is_B_i)                   nxt = FETCH;
                    else if (is_S_i || is_load_i) nxt = MEM;
                    else                          nxt = WB;
            MEM:    if (dmem_ack_i)               nxt = is_S_i ? FETCH : WB;
                    else if (wd_expired)          nxt = TRAP;
            WB:     nxt = FETCH;
            TRAP:   nxt = TRAP;
            default: nxt = TRAP;
        endcase
    end

    // Outputs are forced low while reset is held so an abort is visible at once
    always_comb begin
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        ir_en_o    = 1'b0;
        mdr_en_o   = 1'b0;
        pc_en_o    = 1'b0;
        pc_sel_o   = 1'b0;
        rf_we_o    = 1'b0;
        wb_sel_o   = WB_ALU;
        if (!rst_i) begin
            case (state)
                FETCH: begin
                    imem_req_o = run_i | req_pend;
                    ir_en_o    = (run_i | req_pend) & imem_ack_i;
                end
                EXEC: begin
                    if (is_B_i) begin
                        pc_en_o  = 1'b1;
                        pc_sel_o = br_taken_i;
                    end
                end
                MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = is_S_i;
                    if (dmem_ack_i) begin
                        pc_en_o  = is_S_i;
                        mdr_en_o = !is_S_i;
                    end
                end
                WB: begin
                    rf_we_o  = (rd_addr_i != 5'd0);
                    wb_sel_o = is_load_i ? WB_MEM : (jump ? WB_PC4 : WB_ALU);
                    pc_en_o  = 1'b1;
                    pc_sel_o = jump;
                end
                default: ;
            endcase
        end
    end

    assign err_o   = err;
    assign state_o = state;

    assign wd_count = (imem_req_o & ~imem_ack_i) | (dmem_req_o & ~dmem_ack_i);
    assign wd_clear = imem_ack_i | dmem_ack_i |
                      ((nxt != state) && (nxt == FETCH || nxt == MEM));

    mc_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (wd_clear),
        .count   (wd_count),
        .expired (wd_expired)
    );

`ifdef MC_SEQ_PERF_EN
    logic [31:0] instret, stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instret   <= '0;
            stall_cnt <= '0;
        end else begin
            if (pc_en_o && state != TRAP) instret <= instret + 1'b1;
            if (wd_count)                 stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign instret_o   = instret;
    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the RV32I core. It drives the shared datapath (PC, instruction register, decoder, ALU, register file, data memory port) through fetch, decode, execute, memory and write-back steps using the decoder's class flags. It owns the instruction and data memory request/acknowledge handshakes and traps on an unacknowledged request.

## Interface
- `TIMEOUT`, default 16: number of cycles a memory request may wait for an ack before trapping; range 2..255.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `run_i`  in  1  permits a new instruction fetch.
- `is_R_i`, `is_I_i`, `is_S_i`, `is_B_i`, `is_J_i`, `is_U_i`, `is_load_i`  in  1 each  decoder class flags for the latched instruction.
- `is_jalr_i`  in  1  the latched instruction is JALR (opcode 5'b11001).
- `rd_addr_i`  in  5  destination register.
- `br_taken_i`  in  1  branch comparator result, valid in EXEC.
- `imem_ack_i`  in  1  instruction memory ack; data valid in the same cycle.
- `dmem_ack_i`  in  1  data memory ack; load data valid in the same cycle.
- `imem_req_o`  out  1  instruction fetch request.
- `dmem_req_o`  out  1  data access request.
- `dmem_we_o`  out  1  data access is a store.
- `ir_en_o`  out  1  latch the instruction register.
- `mdr_en_o`  out  1  latch load data.
- `pc_en_o`  out  1  update the PC.
- `pc_sel_o`  out  1  0 selects PC+4, 1 selects the ALU result.
- `rf_we_o`  out  1  register file write enable.
- `wb_sel_o`  out  2  write-back source: 0 ALU, 1 MDR, 2 PC+4.
- `err_o`  out  1  trap flag; sticky.
- `state_o`  out  3  current state, for debug.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH
  - `imem_req_o` = `run_i` OR `req_pend`.
  - `req_pend` is set once the request is issued and holds the request until ack, regardless of `run_i`.
  - On `imem_ack_i`: `ir_en_o` = 1 in the same cycle, then go to DECODE.
- DECODE: one cycle with no strobes; go to EXEC.
- EXEC
  - `is_B_i`: `pc_en_o` = 1, `pc_sel_o` = `br_taken_i`, then FETCH.
  - `is_S_i` or `is_load_i`: go to MEM.
  - Otherwise: go to WB.
- MEM
  - `dmem_req_o` = 1 and `dmem_we_o` = `is_S_i`, held until `dmem_ack_i`.
  - Store ack: `pc_en_o` = 1, `pc_sel_o` = 0, then FETCH.
  - Load ack: `mdr_en_o` = 1, then WB.
- WB
  - `rf_we_o` = 1 only when `rd_addr_i` != 0.
  - `wb_sel_o`: 1 for a load, 2 for `is_J_i` or `is_jalr_i`, else 0.
  - `pc_en_o` = 1; `pc_sel_o` = `is_J_i` OR `is_jalr_i`.
  - Go to FETCH.
- Wait counter
  - Cleared on entering FETCH or MEM and on every ack.
  - Counts each cycle a request is asserted without an ack.
  - When the count reaches `TIMEOUT` with no ack: go to TRAP and set `err_o` = 1.
  - An ack arriving in the same cycle as the limit wins, and no trap is taken.
- TRAP: all strobes and requests are 0. It is left only by reset.
- All outputs are decoded from the state plus the current-cycle inputs listed above. Strobes are single-cycle.

## Timing
- Reset value: state FETCH, `req_pend` = 0, counter = 0, `err_o` = 0; every output 0 except `state_o` = FETCH encoding.
- Reset mid-operation aborts any request immediately, with no completion.
- Minimum latency per class, with zero-wait acks:
  - ALU, U, J, JALR: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle on an ack adds one cycle.
- `run_i` dropping while a fetch is outstanding does not drop `imem_req_o`.
- `run_i` = 0 in FETCH with no pending request idles the sequencer with no request.

## Configuration
- `MC_SEQ_PERF_EN` defined:
  - Adds `instret_o` (out, 32): counts PC updates outside TRAP.
  - Adds `stall_cnt_o` (out, 32): counts cycles with a request asserted and no ack.
  - Both reset to 0 and wrap modulo 2^32.
- `MC_SEQ_PERF_EN` undefined: these ports and counters do not exist.

## Structure
- Package `mc_seq_pkg` holds:
  - the `state_t` enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5);
  - the `wb_sel` constants (WB_ALU, WB_MEM, WB_PC4);
  - the default `TIMEOUT`.
- Sub-module `mc_wdog`: the wait counter. It takes `clear`, `count` and the `TIMEOUT` parameter and outputs `expired`.

## Test plan
- ADD x1,x2,x3 with immediate acks:
  - Cycle-by-cycle state sequence FETCH, DECODE, EXEC, WB, FETCH.
  - `rf_we_o` = 1 and `wb_sel_o` = 0 in WB.
  - `pc_sel_o` = 0 in WB.
- LW x5 with `dmem_ack_i` delayed 3 cycles:
  - `dmem_req_o` held for 4 cycles.
  - `mdr_en_o` pulses on the ack.
  - `wb_sel_o` = 1 in WB; total latency 8 cycles.
- BEQ:
  - `br_taken_i` = 1: `pc_en_o` = 1 and `pc_sel_o` = 1 in EXEC.
  - `br_taken_i` = 0: `pc_sel_o` = 0.
  - Both cases: no WB state and `rf_we_o` never asserts.
- JAL with rd=0, then JALR with rd=1:
  - JAL: `rf_we_o` = 0 in WB.
  - JALR: `rf_we_o` = 1 and `wb_sel_o` = 2.
  - Both: `pc_sel_o` = 1.
- `TIMEOUT` = 4, `imem_ack_i` held low:
  - TRAP is entered once the wait count reaches 4.
  - `err_o` = 1 and stays 1; no further requests are issued.
  - Repeat with the ack arriving exactly on the limit cycle: no trap, DECODE follows.
- `run_i` dropped one cycle after `imem_req_o` rises:
  - The request stays high until the ack, then the instruction completes.
  - Idle afterwards: `imem_req_o` stays 0.
  - Assert `rst_i` mid-MEM: all outputs 0 asynchronously, state FETCH.
